// File: rtl/fa_pipe_if.sv
// fa_pipe_if: operand/result handshake bundle for fa_pipe; flag signals exist only with FA_PIPE_FLAGS_EN
interface fa_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co_top;
    logic             co_msb;
    logic             co_tap;
`ifdef FA_PIPE_FLAGS_EN
    logic             flag_z;
    logic             flag_n;
    logic             flag_v;
    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co_top, co_msb, co_tap, flag_z, flag_n, flag_v
    );
    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co_top, co_msb, co_tap, flag_z, flag_n, flag_v
    );
`else
    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, s, co_top, co_msb, co_tap
    );
    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, s, co_top, co_msb, co_tap
    );
`endif
endinterface

// File: rtl/fa_pipe.sv
// fa_pipe: pipelined add/subtract, SEG bits per stage with registered carries; FA_PIPE_FLAGS_EN adds z/n/v flags
module fa_pipe #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int TAP   = 24
) (
    input logic      sys_clk,
    input logic      reset,
    fa_pipe_if.slave bus
);
    localparam int N = WIDTH / SEG;
    localparam int T = TAP / SEG - 1;
    logic en;
    assign en            = bus.out_ready | ~g_stg[N-1].v_q;
    assign bus.in_ready  = en;
    assign bus.out_valid = g_stg[N-1].v_q;
    assign bus.s         = g_stg[N-1].x_q;
    assign bus.co_top    = g_stg[N-1].c_q;
    assign bus.co_tap    = g_stg[N-1].t_q;
    assign bus.co_msb    = g_stg[N-1].g_last.m_q;
`ifdef FA_PIPE_FLAGS_EN
    assign bus.flag_z    = g_stg[N-1].g_last.z_q;
    assign bus.flag_n    = g_stg[N-1].g_last.n_q;
    assign bus.flag_v    = g_stg[N-1].g_last.fv_q;
`endif
    // Each stage word carries the untouched upper segments of A with the finished
    // lower sum segments spliced in, so after the last stage it is the aligned result.
    for (genvar k = 0; k < N; k++) begin : g_stg
        localparam int LO = k * SEG;
        localparam int BI = WIDTH - LO;
        logic [WIDTH-1:0] x_in;
        logic [WIDTH-1:0] x_d;
        logic [WIDTH-1:0] x_q;
        logic [BI-1:0]    b_in;
        logic [SEG:0]     sum;
        logic             c_in;
        logic             v_in;
        logic             t_d;
        logic             c_q;
        logic             t_q;
        logic             v_q;
        if (k == 0) begin : g_in
            assign x_in = bus.a;
            assign b_in = bus.sub ? ~bus.b : bus.b;
            assign c_in = bus.sub ^ bus.ci;
            assign v_in = bus.in_valid;
        end else begin : g_in
            assign x_in = g_stg[k-1].x_q;
            assign b_in = g_stg[k-1].g_fwd.b_q;
            assign c_in = g_stg[k-1].c_q;
            assign v_in = g_stg[k-1].v_q;
        end
        if (k == T) begin : g_tap
            assign t_d = sum[SEG];
        end else if (k == 0) begin : g_tap
            assign t_d = 1'b0;
        end else begin : g_tap
            assign t_d = g_stg[k-1].t_q;
        end
        assign sum = {1'b0, x_in[LO +: SEG]} + {1'b0, b_in[SEG-1:0]} + {{SEG{1'b0}}, c_in};
        // Replace segment k of the forwarded word with this stage's sum
        always_comb begin
            x_d = x_in;
            x_d[LO +: SEG] = sum[SEG-1:0];
        end
        // Stage register: word, carry, tap carry and valid advance together on en
        always_ff @(posedge sys_clk or posedge reset) begin
            if (reset) begin
                x_q <= '0;
                c_q <= 1'b0;
                t_q <= 1'b0;
                v_q <= 1'b0;
            end else if (en) begin
                x_q <= x_d;
                c_q <= sum[SEG];
                t_q <= t_d;
                v_q <= v_in;
            end
        end
        if (k < N - 1) begin : g_fwd
            logic [BI-SEG-1:0] b_q;
            // Operand B skew: drop the segment consumed here, forward the rest
            always_ff @(posedge sys_clk or posedge reset) begin
                if (reset) b_q <= '0;
                else if (en) b_q <= b_in[BI-1:SEG];
            end
        end
        if (k == N - 1) begin : g_last
            logic m_c;
            logic m_q;
            assign m_c = x_in[WIDTH-1] ^ b_in[SEG-1] ^ sum[SEG-1];
`ifdef FA_PIPE_FLAGS_EN
            logic z_q;
            logic n_q;
            logic fv_q;
            // Carry into the MSB and the status flags, registered alongside the result
            always_ff @(posedge sys_clk or posedge reset) begin
                if (reset) begin
                    m_q  <= 1'b0;
                    z_q  <= 1'b0;
                    n_q  <= 1'b0;
                    fv_q <= 1'b0;
                end else if (en) begin
                    m_q  <= m_c;
                    z_q  <= x_d == '0;
                    n_q  <= x_d[WIDTH-1];
                    fv_q <= sum[SEG] ^ m_c;
                end
            end
`else
            // Carry into the MSB, registered alongside the result
            always_ff @(posedge sys_clk or posedge reset) begin
                if (reset) m_q <= 1'b0;
                else if (en) m_q <= m_c;
            end
`endif
        end
    end
endmodule

// File: tb/tb_fa_pipe.sv
// tb_fa_pipe: directed and random checks of fa_pipe against an arithmetic reference queue
module tb_fa_pipe;
    localparam int W = 32;
    localparam int N = 4;
    typedef struct {
        logic [W-1:0] s;
        logic top, msb, tap, z, n, v;
    } exp_t;
    logic sys_clk;
    logic reset;
    fa_pipe_if #(.WIDTH(W)) bus ();
    fa_pipe #(.WIDTH(W), .SEG(8), .TAP(24)) dut (.sys_clk(sys_clk), .reset(reset), .bus(bus));
    exp_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int popped = 0;
    int first_out = -1;
    int acc_cyc = 0;
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub);
        exp_t m;
        logic [W-1:0] bx;
        logic cin;
        logic [W:0] f;
        logic [W:0] lo;
        logic [W:0] tp;
        bx = sub ? ~b : b;
        cin = sub ? ~ci : ci;
        f = {1'b0, a} + {1'b0, bx} + 33'(cin);
        lo = {2'b0, a[W-2:0]} + {2'b0, bx[W-2:0]} + 33'(cin);
        tp = {9'b0, a[23:0]} + {9'b0, bx[23:0]} + 33'(cin);
        m.s = f[W-1:0];
        m.top = f[W];
        m.msb = lo[W-1];
        m.tap = tp[24];
        m.z = f[W-1:0] == 0;
        m.n = f[W-1];
        m.v = f[W] ^ lo[W-1];
        return m;
    endfunction
    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic step(output bit acc);
        #1;
        acc = 0;
        if (bus.out_valid) begin
            if (q.size() == 0) chk("spurious out_valid", bus.out_valid, 1'b0);
            else begin
                chk("s", bus.s, q[0].s);
                chk("co_top", bus.co_top, q[0].top);
                chk("co_msb", bus.co_msb, q[0].msb);
                chk("co_tap", bus.co_tap, q[0].tap);
`ifdef FA_PIPE_FLAGS_EN
                chk("flag_z", bus.flag_z, q[0].z);
                chk("flag_n", bus.flag_n, q[0].n);
                chk("flag_v", bus.flag_v, q[0].v);
`endif
                if (bus.out_ready) begin
                    void'(q.pop_front());
                    popped++;
                end
            end
            if (first_out < 0) first_out = cyc;
        end
        if (bus.in_valid && bus.in_ready) begin
            q.push_back(model(bus.a, bus.b, bus.ci, bus.sub));
            acc = 1;
        end
        @(posedge sys_clk);
        @(negedge sys_clk);
        cyc++;
    endtask
    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.ci = ci;
        bus.sub = sub;
    endtask
    task automatic drain();
        bit acc;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) step(acc);
        chk("drain left", q.size(), 0);
    endtask
    task automatic chk_reset_outs(input string tag);
        chk({tag, " out_valid"}, bus.out_valid, 1'b0);
        chk({tag, " s"}, bus.s, '0);
        chk({tag, " co_top"}, bus.co_top, 1'b0);
        chk({tag, " co_msb"}, bus.co_msb, 1'b0);
        chk({tag, " co_tap"}, bus.co_tap, 1'b0);
        chk({tag, " in_ready"}, bus.in_ready, 1'b1);
    endtask
    initial begin
        bit acc;
        bit pending;
        int idx;
        int stall;
        int p0;
        reset = 1'b1;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.ci = 1'b0;
        bus.sub = 1'b0;
        bus.out_ready = 1'b0;
        // reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            drive($urandom, $urandom, 1'($urandom), 1'($urandom));
            bus.in_valid = 1'($urandom);
            bus.out_ready = 1'($urandom);
            #1;
            chk_reset_outs("reset");
            @(posedge sys_clk);
            @(negedge sys_clk);
        end
        reset = 1'b0;
        bus.out_ready = 1'b1;
        first_out = -1;
        // directed vectors back to back, first one timed
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        acc_cyc = cyc;
        step(acc);
        chk("first accept", acc, 1'b1);
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        step(acc);
        drive(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        step(acc);
        drive(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
        step(acc);
        drain();
        chk("latency", first_out - acc_cyc, N);
        // six adds into a stalled consumer
        bus.out_ready = 1'b0;
        stall = 0;
        idx = 0;
        p0 = popped;
        for (int i = 0; i < 60 && popped - p0 < 6; i++) begin
            drive(32'(idx), 32'(idx * 256), 1'b0, 1'b0);
            bus.in_valid = idx < 6;
            bus.out_ready = stall >= 5;
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                chk("stall in_ready", bus.in_ready, 1'b0);
                stall++;
            end else if (stall >= 5) chk("no gap", bus.out_valid, 1'b1);
            step(acc);
            if (acc) idx++;
        end
        chk("six results", popped - p0, 6);
        chk("stall cycles", stall, 5);
        chk("six accepted", idx, 6);
        drain();
        // reset with three beats in flight
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, $urandom, 1'($urandom), 1'($urandom));
            step(acc);
        end
        bus.in_valid = 1'b0;
        step(acc);
        chk("pre-reset out_valid", bus.out_valid, 1'b1);
        reset = 1'b1;
        #1;
        chk_reset_outs("mid reset");
        q.delete();
        @(posedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) step(acc);
        first_out = -1;
        drive(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0);
        acc_cyc = cyc;
        step(acc);
        drain();
        chk("post-reset latency", first_out - acc_cyc, N);
        // random traffic with source holding unaccepted beats
        pending = 0;
        for (int i = 0; i < 400; i++) begin
            if (!pending) begin
                drive($urandom_range(0, 3) == 0 ? 32'hFFFF_FFFF : $urandom,
                      $urandom_range(0, 3) == 0 ? 32'h0000_0000 : $urandom,
                      1'($urandom), 1'($urandom));
                bus.in_valid = $urandom_range(0, 3) != 0;
            end
            bus.out_ready = $urandom_range(0, 3) != 0;
            step(acc);
            pending = bus.in_valid && !acc;
        end
        drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fa_pipe.md
# fa_pipe

Parametrised, pipelined add/subtract unit that supersedes the fixed 32-bit combinational full adder in the base cell library. The WIDTH-bit operation is split into SEG-bit segments, one segment per pipeline stage, with the carry registered between stages. The unit provides a valid/ready handshake, an add/subtract mode, and real intermediate carry taps: carry into the MSB and carry out of a configurable boundary. It is used by GPU/DSP address and ALU paths where a full 32-bit ripple does not close timing.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SEG.
- SEG, 8: bits per pipeline stage. Stage count N = WIDTH/SEG; N >= 1.
- TAP, 24: bit boundary for co_tap; a multiple of SEG, 1..WIDTH.

- sys_clk  in  1  clock; all state rises on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operand beat present.
- in_ready  out  1  unit accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- ci  in  1  carry/borrow in.
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result present.
- out_ready  in  1  consumer takes the result this cycle.
- s  out  WIDTH  result.
- co_top  out  1  carry out of bit WIDTH-1.
- co_msb  out  1  carry out of bit WIDTH-2, i.e. into the MSB.
- co_tap  out  1  carry out of bit TAP-1.
- flag_z, flag_n, flag_v  out  1 each  zero/negative/overflow; present only with FA_PIPE_FLAGS_EN.

## Operation
- Effective operands: b' = sub ? ~b : b; cin = sub ? ~ci : ci. With ci=0 and sub=1, the result is a-b. Carries are raw: co_top=1 on subtract means no borrow.
- Stage k (0..N-1) adds segment k of a and b' plus the carry from stage k-1 (cin for k=0), then registers the sum segment and carry-out.
- Segments of a and b' above k travel forward through skew registers. Completed lower sum segments travel forward through deskew registers, so all of s emerges aligned.
- co_msb is computed inside stage N-1 from bit WIDTH-2's carry. co_tap is stage TAP/SEG-1's registered carry, delayed to align with s.
- Global advance enable: en = out_ready | ~out_valid; in_ready = en.
  - When en=1, every stage shifts, along with its valid bit.
  - When en=0, all pipeline registers hold.
  - Bubbles are not compressed.
- A beat is accepted when in_valid & in_ready. in_valid while in_ready=0 is ignored; the source must hold it.
- A result is consumed when out_valid & out_ready.
- Order is strictly preserved; no beat is dropped or duplicated.

## Timing
- Latency: N cycles from acceptance edge to out_valid=1 (N=4 for defaults). Throughput: 1 beat/cycle while out_ready=1.
- N=1: single registered adder, latency 1.
- Reset (async assert, sync deassert by the system) forces:
  - all valid bits 0 and all data/carry registers 0;
  - out_valid=0, s=0, co_*=0, flags=0, in_ready=1.
- Reset mid-operation discards every in-flight beat. No result for a pre-reset beat ever appears.
- Stall: while out_valid=1 & out_ready=0, s, co_*, flags and out_valid are held stable.
- Simultaneous consume and accept in one cycle is legal and yields full throughput.
- Wrap-around: sums are modulo 2^WIDTH. The overflowed carry appears only on co_top.

## Configuration
- FA_PIPE_FLAGS_EN defined: registers flag_z (s==0), flag_n (s[WIDTH-1]) and flag_v (co_top ^ co_msb), aligned with s.
- FA_PIPE_FLAGS_EN undefined: the flag ports and their logic are absent. All other behaviour is identical.

## Test plan
- Reset with inputs toggling -> out_valid=0, s=0, co_top/co_msb/co_tap=0, in_ready=1. After release, the first output appears only N cycles after the first accepted beat.
- Add a=0xFFFFFFFF, b=0x00000001, ci=0 -> 4 cycles later: s=0x00000000, co_top=1, co_msb=1, co_tap=1, flag_z=1, flag_v=0.
- Add a=0x7FFFFFFF, b=0x00000001 -> s=0x80000000, co_msb=1, co_top=0, co_tap=1, flag_n=1, flag_v=1.
- Sub a=0x00000005, b=0x00000007, ci=0 -> s=0xFFFFFFFE, co_top=0 (borrow), flag_n=1, flag_v=0.
- Issue 6 back-to-back adds (i + 0x100·i), then hold out_ready=0 from the first result for 5 cycles -> in_ready=0 and outputs frozen during the stall. After release, all 6 results arrive in order with no gaps or duplicates.
- Assert reset with 3 beats in flight -> out_valid drops immediately. None of the 3 results appears after release; a new beat completes with the correct sum.
